// File: rtl/caf_peak_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : caf_peak_select_pkg
// Purpose  : FSM state encodings and result-word field offsets for CAF peak select.
// Revision : 1.0
// ============================================================================
package caf_peak_select_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam int c_result_bits = 32;
    localparam int c_detect_bit  = 31;
    localparam int c_mag_lsb     = 0;

    function automatic int index_lsb(input int mag_bits);
        return mag_bits;
    endfunction

    function automatic int freq_lsb(input int mag_bits, input int index_bits);
        return mag_bits + index_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/caf_peak_select_peak_compare.sv
`default_nettype none
// ============================================================================
// Module   : caf_peak_select_peak_compare
// Purpose  : Registered compare-and-hold of the running {magnitude, index, bin}.
// Revision : 1.0
// ============================================================================
module caf_peak_select_peak_compare #(
    parameter int MAG_BITS   = 16,
    parameter int INDEX_BITS = 8,
    parameter int FREQ_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  first,
    input  logic [MAG_BITS-1:0]   mag,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [FREQ_BITS-1:0]  bin,
    output logic [MAG_BITS-1:0]   max_mag,
    output logic [INDEX_BITS-1:0] max_index,
    output logic [FREQ_BITS-1:0]  max_bin
);

    logic [MAG_BITS-1:0]   r_mag;
    logic [INDEX_BITS-1:0] r_index;
    logic [FREQ_BITS-1:0]  r_bin;

    // Strict greater-than keeps the lowest bin on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag   <= '0;
            r_index <= '0;
            r_bin   <= '0;
        end else if (load && (first || (mag > r_mag))) begin
            r_mag   <= mag;
            r_index <= index;
            r_bin   <= bin;
        end
    end

    assign max_mag   = r_mag;
    assign max_index = r_index;
    assign max_bin   = r_bin;

endmodule
`default_nettype wire

// File: rtl/caf_peak_select.sv
`default_nettype none
// ============================================================================
// Module   : caf_peak_select
// Purpose  : Per-frame peak search over FOA bins with threshold detect.
// Revision : 1.0
// ============================================================================
module caf_peak_select
    import caf_peak_select_pkg::*;
#(
    parameter int FOA_LEN    = 8,
    parameter int MAG_BITS   = 16,
    parameter int INDEX_BITS = 8,
    parameter int FREQ_BITS  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_axis_tvalid,
    input  logic [INDEX_BITS+MAG_BITS-1:0] m_axis_tdata,
    input  logic                           m_axis_tlast,
    output logic                           s_axis_tready,
    input  logic [MAG_BITS-1:0]            threshold,
    output logic                           s_axis_tvalid,
    output logic [31:0]                    s_axis_tdata,
    input  logic                           m_axis_tready,
    output logic                           frame_err
);

    localparam int                   c_idx_lsb  = index_lsb(MAG_BITS);
    localparam int                   c_freq_lsb = freq_lsb(MAG_BITS, INDEX_BITS);
    localparam logic [FREQ_BITS-1:0] c_last_bin = FREQ_BITS'(FOA_LEN - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_ready;
    logic [FREQ_BITS-1:0]  r_cnt;
    logic [MAG_BITS-1:0]   r_thresh;
    logic                  r_err;
    logic                  w_beat;
    logic                  w_first;
    logic                  w_last_bin;
    logic                  w_done;
    logic [MAG_BITS-1:0]   w_max_mag;
    logic [INDEX_BITS-1:0] w_max_index;
    logic [FREQ_BITS-1:0]  w_max_bin;
    logic [c_result_bits-1:0] w_result;

    assign w_beat     = m_axis_tvalid && r_ready;
    assign w_first    = (r_state == ST_IDLE);
    assign w_last_bin = (r_cnt == c_last_bin);
    assign w_done     = w_beat && (m_axis_tlast || w_last_bin);

    caf_peak_select_peak_compare #(
        .MAG_BITS   (MAG_BITS),
        .INDEX_BITS (INDEX_BITS),
        .FREQ_BITS  (FREQ_BITS)
    ) u_peak_compare (
        .clk       (clk),
        .rst       (rst),
        .load      (w_beat),
        .first     (w_first),
        .mag       (m_axis_tdata[MAG_BITS-1:0]),
        .index     (m_axis_tdata[MAG_BITS +: INDEX_BITS]),
        .bin       (r_cnt),
        .max_mag   (w_max_mag),
        .max_index (w_max_index),
        .max_bin   (w_max_bin)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_beat)        w_state_next = w_done ? ST_EMIT : ST_SCAN;
            ST_SCAN: if (w_done)        w_state_next = ST_EMIT;
            ST_EMIT: if (m_axis_tready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Ready is registered so it stays low through the reset edge and rises one cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            r_thresh <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != ST_EMIT);
            r_err   <= w_done && (m_axis_tlast != w_last_bin);
            if (w_beat && w_first) begin
                r_thresh <= threshold;
            end
            if (w_done) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + FREQ_BITS'(1);
            end
        end
    end

    always_comb begin
        w_result = '0;
        if (r_state == ST_EMIT) begin
            w_result[c_detect_bit]                = (w_max_mag >= r_thresh);
            w_result[c_freq_lsb +: FREQ_BITS]     = w_max_bin;
            w_result[c_idx_lsb +: INDEX_BITS]     = w_max_index;
            w_result[c_mag_lsb +: MAG_BITS]       = w_max_mag;
        end
    end

    assign s_axis_tready = r_ready;
    assign s_axis_tvalid = (r_state == ST_EMIT);
    assign s_axis_tdata  = w_result;
    assign frame_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_caf_peak_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_caf_peak_select
// Purpose  : Directed self-checking bench for caf_peak_select (default parameters).
// Revision : 1.0
// ============================================================================
module tb_caf_peak_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_axis_tvalid;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] threshold;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tready;
    logic        frame_err;

    int n_vec   = 0;
    int n_bad   = 0;
    int n_stall = 0;
    int n_acc   = 0;
    int n_err   = 0;
    logic [31:0] acc_data = '0;

    caf_peak_select dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .threshold     (threshold),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (s_axis_tvalid && m_axis_tready) begin
                n_acc    <= n_acc + 1;
                acc_data <= s_axis_tdata;
            end
            if (frame_err) n_err <= n_err + 1;
        end
    end

    function automatic logic [31:0] exp_word(input logic det, input int bin, input int idx, input int mag);
        logic [2:0]  b = bin[2:0];
        logic [7:0]  i = idx[7:0];
        logic [15:0] m = mag[15:0];
        return {det, 4'b0000, b, i, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns #1 after the edge on which it transferred.
    task automatic send_beat(input int mag, input int idx, input logic last);
        int w;
        logic [15:0] m;
        logic [7:0]  i;
        w = 0;
        m = mag[15:0];
        i = idx[7:0];
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {i, m};
        m_axis_tlast  = last;
        while (!s_axis_tready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_beat_timeout: ready=%0b after %0d cycles, required 1", s_axis_tready, w);
        end
        n_stall += w;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_axis_tvalid = 1'b0; m_axis_tdata = '0; m_axis_tlast = 1'b0;
        threshold = '0; m_axis_tready = 1'b1;
        step(); step();
        n_vec++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
        n_vec++; if (s_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b want 0", s_axis_tvalid); end
        n_vec++; if (s_axis_tdata !== 32'h0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", s_axis_tdata); end
        n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        rst = 1'b0;
        step();
        n_vec++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL post_reset_tready: got %0b want 1", s_axis_tready); end
    endtask

    task automatic test_peak();
        int mags[8] = '{10, 20, 30, 90, 40, 5, 6, 7};
        int a0, e0;
        a0 = n_acc; e0 = n_err;
        threshold = 16'd50;
        for (int b = 0; b < 8; b++) send_beat(mags[b], b * 2, b == 7);
        m_axis_tvalid = 1'b0;
        n_vec++; if (s_axis_tvalid !== 1'b1 || s_axis_tdata !== exp_word(1'b1, 3, 6, 90)) begin
            n_bad++; $display("FAIL peak_result: valid=%0b data=%h want valid=1 data=%h", s_axis_tvalid, s_axis_tdata, exp_word(1'b1, 3, 6, 90)); end
        n_vec++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL peak_emit_tready: got %0b want 0", s_axis_tready); end
        step();
        n_vec++; if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_bad++; $display("FAIL peak_after_accept: valid=%0b ready=%0b want 0/1", s_axis_tvalid, s_axis_tready); end
        n_vec++; if (n_acc - a0 != 1 || n_err != e0) begin
            n_bad++; $display("FAIL peak_counts: accepts=%0d errs=%0d want 1/0", n_acc - a0, n_err - e0); end
    endtask

    task automatic test_tie();
        int a0;
        a0 = n_acc;
        threshold = 16'd200;
        for (int b = 0; b < 8; b++) begin
            send_beat(100, 16 + b, b == 7);
            if (b == 0) threshold = 16'd50;
        end
        m_axis_tvalid = 1'b0;
        n_vec++; if (s_axis_tdata !== exp_word(1'b0, 0, 16, 100)) begin
            n_bad++; $display("FAIL tie_result: got %h want %h", s_axis_tdata, exp_word(1'b0, 0, 16, 100)); end
        step();
        n_vec++; if (n_acc - a0 != 1 || acc_data !== exp_word(1'b0, 0, 16, 100)) begin
            n_bad++; $display("FAIL tie_accept: accepts=%0d data=%h want 1/%h", n_acc - a0, acc_data, exp_word(1'b0, 0, 16, 100)); end
    endtask

    task automatic test_bubbles();
        int mags[8] = '{3, 8, 8, 1, 2, 9, 4, 9};
        int a0;
        logic [31:0] e;
        a0 = n_acc;
        e = exp_word(1'b1, 5, 8'hA5, 9);
        threshold = 16'd9;
        m_axis_tready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            send_beat(mags[b], 8'hA0 + b, b == 7);
            if (b != 7) begin m_axis_tvalid = 1'b0; step(); end
        end
        m_axis_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (s_axis_tvalid !== 1'b1 || s_axis_tdata !== e || s_axis_tready !== 1'b0) begin
                n_bad++; $display("FAIL bubble_hold%0d: valid=%0b ready=%0b data=%h want 1/0/%h", c, s_axis_tvalid, s_axis_tready, s_axis_tdata, e); end
            step();
        end
        m_axis_tready = 1'b1;
        step();
        n_vec++; if (s_axis_tvalid !== 1'b0 || n_acc - a0 != 1 || acc_data !== e) begin
            n_bad++; $display("FAIL bubble_accept: valid=%0b accepts=%0d data=%h want 0/1/%h", s_axis_tvalid, n_acc - a0, acc_data, e); end
    endtask

    task automatic test_frame_err();
        int e0, a0;
        e0 = n_err; a0 = n_acc;
        threshold = 16'd0;
        for (int b = 0; b < 5; b++) send_beat(b + 1, b, b == 4);
        m_axis_tvalid = 1'b0;
        n_vec++; if (frame_err !== 1'b1 || s_axis_tdata !== exp_word(1'b1, 4, 4, 5)) begin
            n_bad++; $display("FAIL short_frame: err=%0b data=%h want 1/%h", frame_err, s_axis_tdata, exp_word(1'b1, 4, 4, 5)); end
        step();
        n_vec++; if (frame_err !== 1'b0 || n_err - e0 != 1 || n_acc - a0 != 1) begin
            n_bad++; $display("FAIL short_pulse: err=%0b pulses=%0d accepts=%0d want 0/1/1", frame_err, n_err - e0, n_acc - a0); end
        for (int b = 0; b < 8; b++) begin
            int m;
            m = (b < 5) ? 5 - b : ((b == 7) ? 6 : 0);
            send_beat(m, b, 1'b0);
        end
        m_axis_tvalid = 1'b0;
        n_vec++; if (frame_err !== 1'b1 || s_axis_tvalid !== 1'b1 || s_axis_tdata !== exp_word(1'b1, 7, 7, 6)) begin
            n_bad++; $display("FAIL notlast_frame: err=%0b valid=%0b data=%h want 1/1/%h", frame_err, s_axis_tvalid, s_axis_tdata, exp_word(1'b1, 7, 7, 6)); end
        step();
        n_vec++; if (frame_err !== 1'b0 || n_err - e0 != 2 || n_acc - a0 != 2) begin
            n_bad++; $display("FAIL notlast_pulse: err=%0b pulses=%0d accepts=%0d want 0/2/2", frame_err, n_err - e0, n_acc - a0); end
    endtask

    task automatic test_reset_abort();
        int a0;
        a0 = n_acc;
        threshold = 16'd50;
        for (int b = 0; b < 4; b++) send_beat(200, b, 1'b0);
        m_axis_tvalid = 1'b0;
        rst = 1'b1;
        step();
        n_vec++; if (s_axis_tready !== 1'b0 || s_axis_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL abort_reset: ready=%0b valid=%0b want 0/0", s_axis_tready, s_axis_tvalid); end
        rst = 1'b0;
        step();
        for (int b = 0; b < 8; b++) send_beat((b == 6) ? 77 : b + 1, 8'h30 + b, b == 7);
        m_axis_tvalid = 1'b0;
        step();
        n_vec++; if (n_acc - a0 != 1 || acc_data !== exp_word(1'b1, 6, 8'h36, 77)) begin
            n_bad++; $display("FAIL abort_result: accepts=%0d data=%h want 1/%h", n_acc - a0, acc_data, exp_word(1'b1, 6, 8'h36, 77)); end
    endtask

    task automatic test_back_to_back();
        int a0, s0;
        a0 = n_acc;
        threshold = 16'd50;
        for (int b = 0; b < 8; b++) send_beat((b == 2) ? 60 : 10, 8'h40 + b, b == 7);
        send_beat_present(50, 8'h50);
        n_vec++; if (s_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || s_axis_tdata !== exp_word(1'b1, 2, 8'h42, 60)) begin
            n_bad++; $display("FAIL b2b_result1: valid=%0b ready=%0b data=%h want 1/0/%h", s_axis_tvalid, s_axis_tready, s_axis_tdata, exp_word(1'b1, 2, 8'h42, 60)); end
        step();
        n_vec++; if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || n_acc - a0 != 1) begin
            n_bad++; $display("FAIL b2b_accept1: valid=%0b ready=%0b accepts=%0d want 0/1/1", s_axis_tvalid, s_axis_tready, n_acc - a0); end
        s0 = n_stall;
        for (int b = 0; b < 8; b++) send_beat((b == 0) ? 50 : b, 8'h50 + b, b == 7);
        m_axis_tvalid = 1'b0;
        n_vec++; if (n_stall != s0 || s_axis_tdata !== exp_word(1'b1, 0, 8'h50, 50)) begin
            n_bad++; $display("FAIL b2b_result2: stalls=%0d data=%h want 0/%h", n_stall - s0, s_axis_tdata, exp_word(1'b1, 0, 8'h50, 50)); end
        step();
        n_vec++; if (n_acc - a0 != 2) begin n_bad++; $display("FAIL b2b_accept2: accepts=%0d want 2", n_acc - a0); end
    endtask

    // Drives the next frame's first beat without waiting, keeping tvalid high through EMIT.
    task automatic send_beat_present(input int mag, input int idx);
        logic [15:0] m;
        logic [7:0]  i;
        m = mag[15:0];
        i = idx[7:0];
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {i, m};
        m_axis_tlast  = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_peak();
        test_tie();
        test_bubbles();
        test_frame_err();
        test_reset_abort();
        test_back_to_back();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
